// File: rtl/uart_tx_top.sv
// Push-button triggered UART transmitter: each debounced press sends "HELLO\n" once.
// Presses arriving while a string is in flight are dropped.
module uart_tx_top #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115_200,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic Clk,
    input  logic Rst_n,
    output logic Rs232_Tx,
    input  logic key,
    output logic led
);

    localparam int BIT_CYC = CLK_FREQ / BAUD;
    localparam int BCW     = $clog2(BIT_CYC + 1);
    localparam int DBW     = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

    logic [1:0]     key_sync;
    logic           key_s;
    logic           key_d;
    logic [DBW-1:0] db_cnt;
    logic           db_state;
    logic           armed;
    logic           press;

    state_t         state, state_nxt;
    logic [2:0]     cnt, cnt_nxt;
    logic           tx_go;
    logic [7:0]     tx_byte;

    logic           busy;
    logic [BCW-1:0] baud_cnt;
    logic [3:0]     bit_idx;
    logic [7:0]     shreg;
    logic           Tx_Done;

    assign key_s = key_sync[1];

    always_ff @(posedge Clk) begin
        if (Rst_n) key_sync <= 2'b11;
        else       key_sync <= {key_sync[0], key};
    end

    // db_cnt counts consecutive clocks of an unchanged synchronized level.
    // armed stays low until a stable release is seen, so a key held through
    // reset cannot fire a press.
    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            key_d    <= 1'b1;
            db_cnt   <= '0;
            db_state <= 1'b1;
            armed    <= 1'b0;
            press    <= 1'b0;
        end else begin
            key_d <= key_s;
            press <= 1'b0;
            if (key_s != key_d) begin
                db_cnt <= '0;
            end else if (db_cnt != DBW'(DEBOUNCE_CYC - 1)) begin
                db_cnt <= db_cnt + 1'b1;
            end else begin
                db_state <= key_s;
                armed    <= armed | key_s;
                press    <= armed & db_state & ~key_s;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            state <= IDLE;
            cnt   <= 3'd0;
            led   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            led   <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tx_go     = 1'b0;
        case (state)
            IDLE: begin
                if (press) begin
                    state_nxt = SEND;
                    cnt_nxt   = 3'd0;
                end
            end
            SEND: begin
                tx_go     = 1'b1;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (Tx_Done) begin
                    if (cnt == 3'd5) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 3'd0;
                    end else begin
                        state_nxt = SEND;
                        cnt_nxt   = cnt + 3'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        case (cnt)
            3'd0:    tx_byte = 8'h48;
            3'd1:    tx_byte = 8'h45;
            3'd2:    tx_byte = 8'h4C;
            3'd3:    tx_byte = 8'h4C;
            3'd4:    tx_byte = 8'h4F;
            default: tx_byte = 8'h0A;
        endcase
    end

    // bit_idx: 0 = start, 1..8 = data LSB first, 9 = stop.
    assign Tx_Done = busy && (bit_idx == 4'd9) && (baud_cnt == BCW'(BIT_CYC - 1));

    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= 4'd0;
            shreg    <= 8'h00;
            Rs232_Tx <= 1'b1;
        end else if (!busy) begin
            if (tx_go) begin
                busy     <= 1'b1;
                baud_cnt <= '0;
                bit_idx  <= 4'd0;
                shreg    <= tx_byte;
                Rs232_Tx <= 1'b0;
            end
        end else if (baud_cnt != BCW'(BIT_CYC - 1)) begin
            baud_cnt <= baud_cnt + 1'b1;
        end else begin
            baud_cnt <= '0;
            if (bit_idx == 4'd9) begin
                busy    <= 1'b0;
                bit_idx <= 4'd0;
            end else begin
                bit_idx  <= bit_idx + 4'd1;
                Rs232_Tx <= (bit_idx == 4'd8) ? 1'b1 : shreg[bit_idx[2:0]];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_top.sv
// Directed bench for uart_tx_top: decodes frames off Rs232_Tx and checks content,
// bit timing, Tx_Done/cnt/led sequencing, debouncing, press filtering and reset.
module tb_uart_tx_top;

    localparam int BIT = 16;   // 1_600_000 / 100_000
    localparam int DB  = 100;

    logic Clk = 1'b0;
    logic Rst_n;
    logic key;
    logic Rs232_Tx;
    logic led;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [7:0] exp_str [6] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0A};

    uart_tx_top #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DEBOUNCE_CYC(DB)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Rs232_Tx(Rs232_Tx), .key(key), .led(led)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) if (dut.Tx_Done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        int viol = 0;
        repeat (n) begin
            @(negedge Clk);
            if (Rs232_Tx !== 1'b1 || led !== 1'b0) viol++;
        end
        chk(tag, viol, 0);
    endtask

    task automatic press_key();
        key = 1'b0;
        repeat (DB + 25) @(negedge Clk);
        key = 1'b1;
    endtask

    task automatic rx_byte(output logic [7:0] b, output int gap, output logic ok,
                           output logic done_end, output logic [2:0] cnt_end, output logic led_end);
        logic [9:0] bits;
        ok = 1'b1;
        gap = 0;
        done_end = 1'b0;
        cnt_end = 3'd7;
        led_end = 1'b0;
        while (Rs232_Tx !== 1'b0 && gap < 4 * BIT) begin
            @(negedge Clk);
            gap++;
        end
        if (Rs232_Tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < BIT; c++) begin
                if (c == 0) bits[i] = Rs232_Tx;
                else if (Rs232_Tx !== bits[i]) ok = 1'b0;
                if (i == 9 && c == BIT - 1) begin
                    done_end = dut.Tx_Done;
                    cnt_end  = dut.cnt;
                    led_end  = led;
                end
                @(negedge Clk);
            end
        end
        b = bits[8:1];
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
    endtask

    // Waits for the accepted press (led rise), then decodes the full string.
    task automatic send_and_check();
        int t = 0;
        int d0;
        logic [7:0] b;
        int gap;
        logic ok, done_end, led_end;
        logic [2:0] cnt_end;
        while (led !== 1'b1 && t < 3 * DB) begin
            @(negedge Clk);
            t++;
        end
        chk("led_rise", led, 1'b1);
        t = 0;
        while (Rs232_Tx !== 1'b0 && t < 5) begin
            @(negedge Clk);
            t++;
        end
        chk("start_latency_le2", (t <= 2), 1'b1);
        d0 = done_cnt;
        for (int k = 0; k < 6; k++) begin
            rx_byte(b, gap, ok, done_end, cnt_end, led_end);
            chk($sformatf("byte%0d", k), b, exp_str[k]);
            chk($sformatf("frame%0d_timing", k), ok, 1'b1);
            chk($sformatf("done_end%0d", k), done_end, 1'b1);
            chk($sformatf("cnt_at_done%0d", k), cnt_end, k);
            chk($sformatf("led_during%0d", k), led_end, 1'b1);
            if (k > 0) chk($sformatf("gap_le2_%0d", k), (gap <= 2), 1'b1);
        end
        chk("led_fall", led, 1'b0);
        chk("cnt_back0", dut.cnt, 3'd0);
        chk("tx_idle_after", Rs232_Tx, 1'b1);
        chk("done_pulses", done_cnt - d0, 6);
    endtask

    task automatic run_press();
        fork
            press_key();
            send_and_check();
        join
    endtask

    task automatic wait_cnt(input logic [2:0] v);
        int t = 0;
        while (dut.cnt !== v && t < 20 * BIT * 10) begin
            @(negedge Clk);
            t++;
        end
        chk($sformatf("reach_cnt%0d", v), dut.cnt, v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        int d0;
        key = 1'b1;
        Rst_n = 1'b1;
        viol = 0;
        repeat (20) begin
            @(negedge Clk);
            if (Rs232_Tx !== 1'b1 || led !== 1'b0 || dut.cnt !== 3'd0 || dut.Tx_Done !== 1'b0) viol++;
        end
        chk("reset_hold", viol, 0);
        Rst_n = 1'b0;
        idle_check("idle_after_reset", 2 * DB);

        // Clean press; release debounce must not start anything.
        run_press();
        idle_check("no_string_on_release", 3 * DB);

        // Bouncing press and bouncing release.
        d0 = done_cnt;
        fork
            begin
                key = 1'b0; repeat (30) @(negedge Clk);
                key = 1'b1; repeat (20) @(negedge Clk);
                key = 1'b0; repeat (40) @(negedge Clk);
                key = 1'b1; repeat (10) @(negedge Clk);
                key = 1'b0; repeat (DB + 25) @(negedge Clk);
                key = 1'b1; repeat (30) @(negedge Clk);
                key = 1'b0; repeat (20) @(negedge Clk);
                key = 1'b1; repeat (15) @(negedge Clk);
                key = 1'b0; repeat (50) @(negedge Clk);
                key = 1'b1;
            end
            send_and_check();
        join
        idle_check("bounce_no_extra", 3 * DB);
        chk("bounce_one_string", done_cnt - d0, 6);

        // Second press during byte 2 is dropped.
        d0 = done_cnt;
        fork
            begin
                press_key();
                wait_cnt(3'd2);
                press_key();
            end
            send_and_check();
        join
        idle_check("second_press_ignored", 3 * DB);
        chk("second_press_total", done_cnt - d0, 6);
        run_press();
        idle_check("idle_after_repress", 2 * DB);

        // Reset during byte 3 aborts the frame.
        fork
            press_key();
        join_none
        wait_cnt(3'd3);
        repeat (40) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("rst_mid_tx", Rs232_Tx, 1'b1);
        chk("rst_mid_led", led, 1'b0);
        chk("rst_mid_cnt", dut.cnt, 3'd0);
        repeat (5) @(negedge Clk);
        Rst_n = 1'b0;
        idle_check("no_resume_after_rst", 2 * DB);
        run_press();

        // Key held low across reset release must not fire.
        key = 1'b0;
        Rst_n = 1'b1;
        repeat (10) @(negedge Clk);
        Rst_n = 1'b0;
        idle_check("held_key_no_press", 3 * DB);
        key = 1'b1;
        repeat (2 * DB) @(negedge Clk);
        run_press();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_top.md
UART_TX_TOP -- requirements
Module: uart_tx_top

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115_200, serial bit rate; bit period BIT_CYC = CLK_FREQ/BAUD, truncated (434 at defaults).
REQ-003 Parameter DEBOUNCE_CYC, default 1_000_000 (20 ms), key stable time required to accept a level change.
REQ-004 Port Clk  input  1  system clock; all logic on rising edge.
REQ-005 Port Rst_n  input  1  reset; synchronous, active-high (1 = reset); sampled on rising Clk.
REQ-006 Port Rs232_Tx  output  1  UART serial output, idle high.
REQ-007 Port key  input  1  raw asynchronous push-button, active-low (0 = pressed), bouncing.
REQ-008 Port led  output  1  high while a string transmission is in progress.
REQ-009 Internal signal Tx_Done (1 bit) and internal register cnt (3 bits) SHALL exist under exactly these names for hierarchical probing.

Function
REQ-010 key SHALL pass through a 2-flop synchronizer before any use.
REQ-011 Debouncer SHALL accept a new key level only after the synchronized key holds that level for DEBOUNCE_CYC consecutive clocks; any bounce restarts the count.
REQ-012 Accepted 1->0 transition SHALL produce a one-clock press pulse; release (0->1) SHALL produce no pulse.
REQ-013 Press pulse while idle SHALL start transmission of the fixed 6-byte string 0x48,0x45,0x4C,0x4C,0x4F,0x0A ("HELLO\n"), indexed by cnt = 0..5.
REQ-014 Press pulse while a string is in progress SHALL be ignored; no queuing.
REQ-015 Byte frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly BIT_CYC clocks.
REQ-016 Start bit of byte 0 SHALL appear on Rs232_Tx no later than 3 clocks after the press pulse.
REQ-017 Tx_Done SHALL pulse high for exactly one clock at the end of each byte's stop bit.
REQ-018 On Tx_Done with cnt < 5: cnt increments by 1; next byte's start bit begins within 2 clocks.
REQ-019 On Tx_Done with cnt == 5: string complete; cnt returns to 0; led falls on the next clock; Rs232_Tx stays high.
REQ-020 led SHALL rise in the clock after the accepted press pulse and remain high until string completion.
REQ-021 Rs232_Tx SHALL be registered (glitch-free) and high whenever no frame is being sent.
REQ-022 Controller states: IDLE (wait press) -> SEND (byte cnt active) -> WAIT_DONE (await Tx_Done) -> SEND or IDLE per REQ-018/019.

Reset
REQ-023 While Rst_n = 1: Rs232_Tx = 1, led = 0, Tx_Done = 0, cnt = 0, controller IDLE, baud/bit counters 0, debouncer state = released (1), counter 0.
REQ-024 Reset asserted mid-frame SHALL abort immediately; after release no partial byte resumes and the next press restarts from byte 0.
REQ-025 Key held low across reset release SHALL NOT produce a press pulse until released and pressed again.

Verification
REQ-026 Reset 20 clocks, key high -> Rs232_Tx = 1, led = 0, cnt = 0 throughout; no Tx_Done.
REQ-027 Clean press (DEBOUNCE_CYC overridden to 100), held 20 clocks past acceptance -> 6 frames decode to 48 45 4C 4C 4F 0A; 6 Tx_Done pulses; last pulse coincides with cnt == 5; led low 1 clock later.
REQ-028 Bouncing press (pulses shorter than DEBOUNCE_CYC, then stable low) -> exactly one string sent; bounces during release -> no extra string.
REQ-029 Bit timing -> every bit exactly 434 clocks at defaults; stop-bit-to-next-start gap ≤ 2 clocks.
REQ-030 Second press during byte 2 -> ignored; exactly 6 bytes total; new press after completion -> full string again.
REQ-031 Reset asserted during byte 3 -> Rs232_Tx high and led low on next clock; following press sends full string from 0x48.
